// File: rtl/branch_predictor_btb_pkg.sv
// Shared predictor types: counter encodings, saturating helpers, default entry layout.
// Pure declarations; no timing or flow-control behaviour of its own.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt2_e;

  // Widest counter the helpers handle; callers narrow the result.
  localparam int CNT_MAX_W = 8;

  localparam int BP_ADDR_W = 32;
  localparam int BP_IDX_W  = 6;
  localparam int BP_CNT_W  = 2;
  localparam int BP_TAG_W  = BP_ADDR_W - BP_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CNT_W-1:0]  cnt;
  } bp_entry_t;

  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [CNT_MAX_W-1:0] top_val;
    top_val = CNT_MAX_W'((1 << w) - 1);
    return (v >= top_val) ? top_val : v + 1'b1;
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, decode resolve and mispredict signals between pipeline and predictor.
// No handshake: fetch is combinational, resolve is a single-cycle valid pulse.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
);
  logic [ADDR_W-1:0] pc_f;
  logic              pred_hit_f;
  logic              pred_taken_f;
  logic [ADDR_W-1:0] pred_target_f;
  logic [IDX_W-1:0]  pred_idx_f;

  logic              resolve_valid_d;
  logic [ADDR_W-1:0] resolve_pc_d;
  logic [IDX_W-1:0]  resolve_idx_d;
  logic              resolve_taken_d;
  logic [ADDR_W-1:0] resolve_target_d;
  logic              resolve_pred_taken_d;
  logic [ADDR_W-1:0] resolve_pred_target_d;
  logic              invalidate_all;

  logic              mispredict_taken_d;
  logic              mispredict_not_taken_d;
  logic              mispredict_taken_q;
  logic              mispredict_not_taken_q;
  logic [ADDR_W-1:0] redirect_pc_d;

  modport master (
    output pc_f, resolve_valid_d, resolve_pc_d, resolve_idx_d, resolve_taken_d,
           resolve_target_d, resolve_pred_taken_d, resolve_pred_target_d, invalidate_all,
    input  pred_hit_f, pred_taken_f, pred_target_f, pred_idx_f,
           mispredict_taken_d, mispredict_not_taken_d, mispredict_taken_q,
           mispredict_not_taken_q, redirect_pc_d
  );

  modport slave (
    input  pc_f, resolve_valid_d, resolve_pc_d, resolve_idx_d, resolve_taken_d,
           resolve_target_d, resolve_pred_taken_d, resolve_pred_target_d, invalidate_all,
    output pred_hit_f, pred_taken_f, pred_target_f, pred_idx_f,
           mispredict_taken_d, mispredict_not_taken_d, mispredict_taken_q,
           mispredict_not_taken_q, redirect_pc_d
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Next value of a CNT_W-bit saturating up/down counter.
// Purely combinational, zero latency, no backpressure.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] nxt
);

  logic [CNT_MAX_W-1:0] cnt_ext;
  logic [CNT_MAX_W-1:0] inc_val;
  logic [CNT_MAX_W-1:0] dec_val;

  assign cnt_ext = CNT_MAX_W'(cnt);
  assign inc_val = sat_inc(cnt_ext, CNT_W);
  assign dec_val = sat_dec(cnt_ext);

  always_comb begin
    nxt = CNT_W'(dec_val);
    if (up) begin
      nxt = CNT_W'(inc_val);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// BTB with per-entry saturating direction counters, bimodal or gshare indexed.
// Lookup is combinational; resolve updates at the edge; mispredicts comb plus one-cycle registered.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_btb_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;

  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};

  entry_t           tbl [ENTRIES];
  logic [GW-1:0]    ghr;

  // Lookup path
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  entry_t           look_e;

  assign look_idx = bus.pc_f[IDX_W+1:2] ^ IDX_W'(ghr);
  assign look_tag = bus.pc_f[ADDR_W-1:IDX_W+2];
  assign look_e   = tbl[look_idx];

  assign bus.pred_idx_f    = look_idx;
  assign bus.pred_target_f = look_e.target;
  assign bus.pred_hit_f    = look_e.valid && (look_e.tag == look_tag);
  assign bus.pred_taken_f  = bus.pred_hit_f && look_e.cnt[CNT_W-1];

  // Resolve path
  entry_t           res_e;
  logic [TAG_W-1:0] res_tag;
  logic             res_match;
  logic [CNT_W-1:0] cnt_nxt;
  logic             upd_en;
  entry_t           upd_e;

  assign res_e     = tbl[bus.resolve_idx_d];
  assign res_tag   = bus.resolve_pc_d[ADDR_W-1:IDX_W+2];
  assign res_match = res_e.valid && (res_e.tag == res_tag);

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt (res_e.cnt),
    .up  (bus.resolve_taken_d),
    .nxt (cnt_nxt)
  );

  always_comb begin
    upd_en = 1'b0;
    upd_e  = res_e;
    if (bus.resolve_valid_d) begin
      if (res_match) begin
        upd_en    = 1'b1;
        upd_e.cnt = cnt_nxt;
        if (bus.resolve_taken_d) begin
          upd_e.target = bus.resolve_target_d;
        end
      end else if (bus.resolve_taken_d) begin
        upd_en = 1'b1;
        upd_e  = '{valid: 1'b1, tag: res_tag, target: bus.resolve_target_d, cnt: CNT_WEAK_T};
      end
    end
  end

  // invalidate_all wins over a same-cycle resolve, which is dropped entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= RST_ENTRY;
      end
    end else if (bus.invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else if (upd_en) begin
      tbl[bus.resolve_idx_d] <= upd_e;
    end
  end

  generate
    if (GHR_W > 0) begin : g_ghr
      // History is non-speculative: it shifts only on a resolved branch.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (bus.invalidate_all) begin
          ghr <= '0;
        end else if (bus.resolve_valid_d) begin
          ghr <= GW'({ghr, bus.resolve_taken_d});
        end
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  // Mispredict detection and redirect
  logic mp_taken;
  logic mp_not_taken;

  assign mp_taken = bus.resolve_valid_d && bus.resolve_taken_d &&
                    (!bus.resolve_pred_taken_d ||
                     (bus.resolve_pred_target_d != bus.resolve_target_d));
  assign mp_not_taken = bus.resolve_valid_d && !bus.resolve_taken_d &&
                        bus.resolve_pred_taken_d;

  assign bus.mispredict_taken_d     = mp_taken;
  assign bus.mispredict_not_taken_d = mp_not_taken;
  assign bus.redirect_pc_d = bus.resolve_taken_d ? bus.resolve_target_d
                                                 : bus.resolve_pc_d + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mispredict_taken_q     <= 1'b0;
      bus.mispredict_not_taken_q <= 1'b0;
    end else begin
      bus.mispredict_taken_q     <= mp_taken;
      bus.mispredict_not_taken_q <= mp_not_taken;
    end
  end

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.pc_f[1:0];

endmodule
